price_bcd_conv: RTL and testbench
=================================

# price_bcd_conv

Sequential binary-to-BCD converter for the scale's final price. Sits directly downstream of the price multiplier. It takes the 19-bit price in cents (`precof`) and produces six packed BCD digits for the price display driver. Conversion uses the shift-and-add-3 (double-dabble) algorithm, one bit per clock.

## Interface
Parameters:
- `BIN_W`, default 19: binary input width. Matches `precof`.
- `DIGITS`, default 6: BCD digit count. Must satisfy 10^DIGITS > 2^BIN_W − 1.

Ports:
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `precof` input BIN_W: price in cents, unsigned. Sampled only when a `start` is accepted.
- `start` input 1: conversion request, sampled on the rising edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `bcd` is updated.
- `bcd` output 4*DIGITS: packed BCD.
  - `bcd[3:0]` is the units of cents; `bcd[23:20]` is the most significant digit.
  - Decimal point sits between digit 2 and digit 1 (display-side).
- `blank` output DIGITS: leading-zero blanking mask, bit i set means digit i is blank. See Configuration.

## Operation
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE:
  - `busy`=0.
  - On `start`=1, capture `precof` into the shift register, clear the BCD working register, load the bit counter with BIN_W−1, and go to SHIFT.
- SHIFT:
  - `busy`=1.
  - Each cycle, every working-register digit ≥5 gets +3. The combined {BCD, binary} register then shifts left by one, with the binary MSB entering BCD bit 0.
  - The counter decrements each cycle. After the cycle in which the counter is 0, go to DONE.
  - Exactly BIN_W shift cycles occur per conversion.
- DONE:
  - `busy`=0 and `done`=1 for this one cycle.
  - The output register `bcd` (and `blank`) is loaded from the working register on the edge entering DONE.
  - Next state is IDLE. If `start`=1 in this cycle, the request is accepted and the next state is SHIFT with the new `precof` captured.
- `start` while in SHIFT is ignored. It is not queued.
- `bcd` holds its last result between conversions. It changes only on entry to DONE.
- Input range:
  - All values 0..2^BIN_W−1 are legal. The maximum, 524287, converts to 524287.
  - No overflow path exists. The DIGITS constraint guarantees this.
- Reset mid-conversion:
  - All state is cleared immediately (asynchronous) and the FSM goes to IDLE.
  - No `done` is produced for the aborted conversion.
  - `bcd` is 0.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `bcd`=0.
  - `blank`=6'b111000 with `PRICE_BLANK_EN` defined, 0 otherwise.
  - FSM is in IDLE and the counter is 0.
- Let `start` be sampled at edge N:
  - `busy` is high after edges N .. N+BIN_W−1.
  - The edge N+BIN_W enters DONE: `bcd` is valid and `done`=1 during the cycle after edge N+BIN_W.
  - Latency is BIN_W+1 = 20 cycles from `start` to `done`.
- Back-to-back conversions: `start` asserted in the DONE cycle gives a throughput of one result per 20 cycles.
- All outputs are registered. No combinational input-to-output paths.

## Configuration
- Macro: `PRICE_BLANK_EN`.
- Defined:
  - `blank` is computed and registered together with `bcd`.
  - Bit i is set when digit i and all higher digits are 0, for i ≥ 3 only.
  - Digits 0..2 are never blanked, so a price always shows as at least "0.00".
- Undefined: `blank` is tied to 0. No blanking logic is synthesized.

## Test plan
- Reset, then `start` with `precof`=0: `done` after 20 cycles, `bcd`=24'h000000, `blank`=6'b111000 (EN) or 0.
- `precof`=705 (1500 g × 470 c/kg): `bcd`=24'h000705, `blank`=6'b111000 (EN).
- `precof`=524287: `bcd`=24'h524287, `blank`=0. Also `precof`=100000: `bcd`=24'h100000.
- `start` pulsed again 5 cycles into a conversion with a different `precof`: ignored, a single `done` with the first value only, `busy` continuous.
- `reset` asserted 10 cycles into a conversion of 12345: `busy`/`done`/`bcd` go to 0 immediately, and no `done` appears. The next conversion of 12345 gives 24'h012345, `blank`=6'b100000 (EN).
- `start` held in the DONE cycle with `precof`=999: the second `done` follows exactly 20 cycles after the first, `bcd`=24'h000999.

Source files
------------

// File: rtl/price_bcd_conv.sv
// Sequential binary-to-BCD converter for the scale price, one double-dabble step per clock.
// Optional leading-zero blanking mask is built when PRICE_BLANK_EN is defined.
module price_bcd_conv #(
  parameter int BIN_W  = 19,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_W-1:0]      precof,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [4*DIGITS-1:0] work_q, work_d;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] shifted;
  logic [4*DIGITS-1:0] bcd_q;
  logic                load_out;

  // Add-3 correction on every digit that would overflow past 9 after doubling.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (work_q[gi*4 +: 4] >= 4'd5) ? (work_q[gi*4 +: 4] + 4'd3)
                                                          : work_q[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {adj[4*DIGITS-2:0], bin_q[BIN_W-1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    work_d   = work_q;
    load_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = precof;
          work_d  = '0;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted;
        bin_d  = {bin_q[BIN_W-2:0], 1'b0};
        if (cnt_q == '0) begin
          load_out = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          bin_d   = precof;
          work_d  = '0;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      if (load_out) bcd_q <= shifted;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign bcd  = bcd_q;

`ifdef PRICE_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-3){1'b1}}, 3'b000};

  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;

  // Digits 0..2 always show so the display reads at least "0.00".
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
      if (gi >= 3) begin : g_hi
        assign blank_d[gi] = ~|shifted[4*DIGITS-1:4*gi];
      end else begin : g_lo
        assign blank_d[gi] = 1'b0;
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_q <= BLANK_RST;
    end else if (load_out) begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_price_bcd_conv.sv
// Self-checking bench for price_bcd_conv: directed cases, random prices, start/reset corner cases.
module tb_price_bcd_conv;

  localparam int BIN_W  = 19;
  localparam int DIGITS = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [BIN_W-1:0]  precof = '0;
  logic              start = 1'b0;
  logic              busy;
  logic              done;
  logic [23:0]       bcd;
  logic [5:0]        blank;

  int total = 0;
  int bad   = 0;

  price_bcd_conv #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .precof(precof), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .blank(blank)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] model_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [5:0] model_blank(input int v);
    logic [5:0] r;
    int p;
    r = '0;
`ifdef PRICE_BLANK_EN
    p = 1000;
    for (int i = 3; i < 6; i++) begin
      r[i] = (v < p);
      p = p * 10;
    end
`else
    p = 0;
`endif
    return r;
  endfunction

  function automatic logic [5:0] reset_blank();
`ifdef PRICE_BLANK_EN
    return 6'b111000;
`else
    return 6'b000000;
`endif
  endfunction

  // Issue one start and wait for done; lat is edges after the accepting edge (-1 on timeout).
  task automatic do_conv(input int v, output int lat, output bit busy_gap);
    precof = BIN_W'(v);
    start  = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    lat      = 0;
    busy_gap = !busy;
    while (lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (!busy) busy_gap = 1'b1;
    end
    if (!done) lat = -1;
    $display("conv precof=%0d bcd=%h blank=%b latency=%0d", v, bcd, blank, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
    end
    total++;
    if (bcd !== 24'h0) begin
      bad++; $display("FAIL reset_bcd got=%h required=000000", bcd);
    end
    total++;
    if (blank !== reset_blank()) begin
      bad++; $display("FAIL reset_blank got=%b required=%b", blank, reset_blank());
    end
  endtask

  task automatic test_directed();
    int vals[4] = '{0, 705, 524287, 100000};
    int lat;
    bit gap;
    foreach (vals[k]) begin
      do_conv(vals[k], lat, gap);
      total++;
      if (lat !== 19 || gap) begin
        bad++; $display("FAIL dir_timing v=%0d lat=%0d gap=%0d required lat=19 gap=0", vals[k], lat, gap);
      end
      total++;
      if (bcd !== model_bcd(vals[k])) begin
        bad++; $display("FAIL dir_bcd v=%0d got=%h required=%h", vals[k], bcd, model_bcd(vals[k]));
      end
      total++;
      if (blank !== model_blank(vals[k])) begin
        bad++; $display("FAIL dir_blank v=%0d got=%b required=%b", vals[k], blank, model_blank(vals[k]));
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || bcd !== model_bcd(vals[k])) begin
        bad++; $display("FAIL dir_hold v=%0d done=%b bcd=%h required done=0 bcd=%h", vals[k], done, bcd, model_bcd(vals[k]));
      end
    end
  endtask

  task automatic test_random();
    int v, lat;
    bit gap;
    for (int k = 0; k < 24; k++) begin
      case (k % 4)
        0: v = int'($urandom_range(0, 999));
        1: v = int'($urandom_range(1000, 99999));
        default: v = int'($urandom_range(0, 524287));
      endcase
      do_conv(v, lat, gap);
      total++;
      if (lat !== 19 || gap || bcd !== model_bcd(v) || blank !== model_blank(v)) begin
        bad++;
        $display("FAIL rand v=%0d lat=%0d gap=%0d bcd=%h blank=%b required lat=19 gap=0 bcd=%h blank=%b",
                 v, lat, gap, bcd, blank, model_bcd(v), model_blank(v));
      end
    end
  endtask

  task automatic test_ignored_start();
    int ndone = 0, first = -1;
    bit gap = 0;
    precof = BIN_W'(4242);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5) begin precof = BIN_W'(77777); start = 1'b1; end
      if (c == 6) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; if (first < 0) first = c; end
      if (first < 0 && !busy) gap = 1'b1;
    end
    $display("ignored_start ndone=%0d first=%0d bcd=%h", ndone, first, bcd);
    total++;
    if (ndone !== 1 || first !== 19 || gap) begin
      bad++; $display("FAIL ignored_start ndone=%0d first=%0d gap=%0d required 1 19 0", ndone, first, gap);
    end
    total++;
    if (bcd !== model_bcd(4242)) begin
      bad++; $display("FAIL ignored_bcd got=%h required=%h", bcd, model_bcd(4242));
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0, lat;
    bit gap;
    precof = BIN_W'(12345);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 24'h0 || blank !== reset_blank()) begin
      bad++; $display("FAIL reset_mid busy=%b done=%b bcd=%h blank=%b required 0 0 000000 %b",
                      busy, done, bcd, blank, reset_blank());
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++; $display("FAIL reset_mid_quiet activity=%0d required=0", ndone);
    end
    do_conv(12345, lat, gap);
    total++;
    if (lat !== 19 || bcd !== 24'h012345 || blank !== model_blank(12345)) begin
      bad++; $display("FAIL reset_mid_next lat=%0d bcd=%h blank=%b required 19 012345 %b",
                      lat, bcd, blank, model_blank(12345));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, n = 0;
    bit gap;
    do_conv(4321, lat, gap);
    total++;
    if (lat !== 19 || bcd !== model_bcd(4321)) begin
      bad++; $display("FAIL b2b_first lat=%0d bcd=%h required 19 %h", lat, bcd, model_bcd(4321));
    end
    precof = BIN_W'(999);
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept busy=%b required=1", busy);
    end
    while (n < 60 && !done) begin
      @(posedge clk); #1;
      n++;
    end
    $display("b2b second done gap=%0d bcd=%h", n, bcd);
    total++;
    if (n !== 20 || bcd !== 24'h000999 || blank !== model_blank(999)) begin
      bad++; $display("FAIL b2b_second gap=%0d bcd=%h blank=%b required 20 000999 %b",
                      n, bcd, blank, model_blank(999));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
